tribonacci_seq_ctrl: RTL and testbench
======================================

Name: tribonacci_seq_ctrl

Overview:
- Request/response controller that computes the n-th tribonacci term T(n) on demand.
- It owns a 3-register tribonacci datapath and sequences it: seed load, n shift steps, then result presentation.
- Requesters get a valid/ready command port and a valid/ready result port with overflow status and abort.
- Sequence definition: T(0)=0, T(1)=1, T(2)=1, T(k)=T(k-1)+T(k-2)+T(k-3).

Parameters:
- WIDTH, 32, datapath and result width in bits.
- NW, 8, width of the requested index n.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  command valid.
- req_ready  out  1  command accepted when req_valid && req_ready.
- req_n  in  NW  index n of the term to compute; sampled on acceptance.
- abort  in  1  cancel the current job.
- res_valid  out  1  result valid.
- res_ready  in  1  result consumed when res_valid && res_ready.
- res_data  out  WIDTH  T(n) mod 2^WIDTH.
- res_ovf  out  1  set if any addition contributing to res_data exceeded WIDTH bits.
- busy  out  1  high in RUN and DONE.

Behaviour:
- Reset is rst, asynchronous, active-high; clock is clk. Reset values:
  - state=IDLE, req_ready=1, res_valid=0, busy=0.
  - res_data=0, res_ovf=0, counter=0.
  - Datapath r0=0, r1=1, r2=1; all overflow flags 0.
- States IDLE, RUN, DONE. req_ready = (state==IDLE), res_valid = (state==DONE), busy = !IDLE.
- IDLE:
  - On acceptance, load r0/r1/r2 = 0/1/1, clear flags f0/f1/f2, set cnt=req_n, go RUN.
  - abort is ignored in IDLE.
- RUN, cnt!=0: shift r0<=r1, r1<=r2, r2<=r0+r1+r2 (truncated to WIDTH); cnt<=cnt-1.
- RUN, cnt==0: no shift; go DONE.
- DONE:
  - res_data=r0 and res_ovf=f0, both driven from registers and held stable.
  - On res_ready, go IDLE; datapath holds its value.
- Latency: acceptance in cycle C0 gives res_valid first high in cycle C0+n+2. Earliest next acceptance is the cycle after result consumption (no back-to-back overlap).
- Overflow tracking: each register has a flag that shifts with its value.
  - New f2 = carry-out of the 3-operand sum (bits above WIDTH nonzero) OR f0 OR f1 OR f2.
  - The sum is computed WIDTH+2 bits wide.
  - res_ovf reflects only overflow that feeds r0, not look-ahead overflow in r1/r2.
- Abort:
  - abort in RUN or DONE sends the FSM to IDLE on the next edge.
  - No result is produced; res_valid drops the cycle after abort.
  - abort has priority over res_ready in the same cycle.
- Boundary conditions:
  - n=0 returns 0 with latency 2.
  - The counter never wraps: it decrements only when nonzero.
  - req_n=2^NW-1 is legal and simply runs long.
- Reset mid-operation aborts immediately and returns all registers to their reset values.

Decomposition:
- Package tribonacci_pkg holds:
  - state encoding (IDLE=0, RUN=1, DONE=2, 2-bit);
  - seed constants TRIB_SEED0=0, TRIB_SEED1=1, TRIB_SEED2=1.
- Sub-module tribo_core is the datapath:
  - 3 value registers + 3 flag registers, 3-operand adder with carry detect;
  - inputs load and shift; outputs r0 and f0.
- The controller contains the FSM and counter and instantiates one tribo_core.

Test Plan:
- Reset, then req_n=10 with res_ready=1: res_valid rises exactly 12 cycles after acceptance with res_data=149, res_ovf=0.
- req_n=0: res_data=0 after 2 cycles; then req_n=1 and req_n=2 back to back each return 1.
- req_n=38: res_data=3831006429, res_ovf=0. req_n=39: res_data=2751352088, res_ovf=1.
- Backpressure with req_n=5 and res_ready=0 for 7 cycles: res_valid and res_data=7 held stable, req_ready=0 throughout; single consume on res_ready.
- Abort: accept req_n=20, assert abort 5 cycles later → IDLE next cycle, no res_valid. Next req_n=4 returns 4 with no stale state.
- Reset mid-run: assert rst while in RUN with req_n=30 → outputs reach reset values asynchronously. After release, req_n=7 returns 24.

Source files
------------

// File: rtl/tribonacci_pkg.sv
// tribonacci_pkg: shared FSM encoding and seed constants for the tribonacci
// sequencing controller and its datapath.
package tribonacci_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int TRIB_SEED0 = 0;
    localparam int TRIB_SEED1 = 1;
    localparam int TRIB_SEED2 = 1;
endpackage

// File: rtl/tribo_core.sv
// tribo_core: three-register tribonacci shifter with per-register overflow flags
// that travel alongside their values.
module tribo_core
    import tribonacci_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_shift,
    output logic [WIDTH-1:0] o_r0,
    output logic             o_f0
);
    logic [WIDTH-1:0] r_v0, r_v1, r_v2;
    logic             r_f0, r_f1, r_f2;
    logic [WIDTH+1:0] w_sum;
    logic             w_carry;

    // Two guard bits are enough for the sum of three WIDTH-bit operands.
    assign w_sum   = {2'b00, r_v0} + {2'b00, r_v1} + {2'b00, r_v2};
    assign w_carry = |w_sum[WIDTH+1:WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst || i_load) begin
            r_v0 <= WIDTH'(TRIB_SEED0);
            r_v1 <= WIDTH'(TRIB_SEED1);
            r_v2 <= WIDTH'(TRIB_SEED2);
            r_f0 <= 1'b0;
            r_f1 <= 1'b0;
            r_f2 <= 1'b0;
        end else if (i_shift) begin
            r_v0 <= r_v1;
            r_v1 <= r_v2;
            r_v2 <= w_sum[WIDTH-1:0];
            r_f0 <= r_f1;
            r_f1 <= r_f2;
            r_f2 <= w_carry | r_f0 | r_f1 | r_f2;
        end
    end

    assign o_r0 = r_v0;
    assign o_f0 = r_f0;
endmodule

// File: rtl/tribonacci_seq_ctrl.sv
// tribonacci_seq_ctrl: valid/ready request/response controller that sequences a
// tribo_core to return T(n), with overflow status and abort.
module tribonacci_seq_ctrl
    import tribonacci_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NW    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [NW-1:0]    req_n,
    input  logic             abort,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_ovf,
    output logic             busy
);
    state_t           r_state;
    logic [NW-1:0]    r_cnt;
    logic             r_req_ready, r_res_valid, r_busy, r_res_ovf;
    logic [WIDTH-1:0] r_res_data;
    logic             w_load, w_shift, w_f0;
    logic [WIDTH-1:0] w_r0;

    assign w_load  = (r_state == IDLE) && req_valid;
    assign w_shift = (r_state == RUN) && !abort && (r_cnt != '0);

    tribo_core #(.WIDTH(WIDTH)) u_core (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_shift (w_shift),
        .o_r0    (w_r0),
        .o_f0    (w_f0)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_req_ready <= 1'b1;
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_res_data  <= '0;
            r_res_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (req_valid) begin
                    r_state     <= RUN;
                    r_cnt       <= req_n;
                    r_req_ready <= 1'b0;
                    r_busy      <= 1'b1;
                end
                RUN: if (abort) begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b1;
                    r_busy      <= 1'b0;
                end else if (r_cnt != '0) begin
                    r_cnt <= r_cnt - NW'(1);
                end else begin
                    r_state     <= DONE;
                    r_res_valid <= 1'b1;
                    r_res_data  <= w_r0;
                    r_res_ovf   <= w_f0;
                end
                DONE: if (abort || res_ready) begin
                    r_state     <= IDLE;
                    r_res_valid <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_busy      <= 1'b0;
                end
                default: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b1;
                    r_res_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign res_valid = r_res_valid;
    assign busy      = r_busy;
    assign res_data  = r_res_data;
    assign res_ovf   = r_res_ovf;
endmodule

// File: tb/tb_tribonacci_seq_ctrl.sv
// tb_tribonacci_seq_ctrl: directed-vector bench for tribonacci_seq_ctrl with
// hand-computed tribonacci terms.
module tb_tribonacci_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [7:0]  req_n = '0;
    logic        abort = 1'b0;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [31:0] res_data;
    logic        res_ovf;
    logic        busy;
    int          checks = 0;
    int          failures = 0;

    tribonacci_seq_ctrl #(.WIDTH(32), .NW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_n     (req_n),
        .abort     (abort),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_ovf   (res_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [7:0] n);
        int w = 0;
        while (!req_ready && w < 50) begin
            tick();
            w++;
        end
        chk("req_ready_before_accept", req_ready, 1);
        req_n = n;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic job(input logic [7:0] n, input logic [31:0] d, input logic ovf, input int hold);
        int lat = 1;
        res_ready = (hold == 0);
        accept(n);
        while (!res_valid && lat < 400) begin
            tick();
            lat++;
        end
        chk($sformatf("latency_n%0d", n), lat, n + 2);
        chk($sformatf("data_n%0d", n), res_data, d);
        chk($sformatf("ovf_n%0d", n), res_ovf, ovf);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_valid", res_valid, 1);
            chk("hold_data", res_data, d);
            chk("hold_req_ready", req_ready, 0);
        end
        res_ready = 1'b1;
        tick();
        chk($sformatf("consumed_n%0d", n), res_valid, 0);
        chk($sformatf("idle_ready_n%0d", n), req_ready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        #13;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_ovf", res_ovf, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        job(8'd10, 32'd149, 1'b0, 0);
        job(8'd0, 32'd0, 1'b0, 0);
        job(8'd1, 32'd1, 1'b0, 0);
        job(8'd2, 32'd1, 1'b0, 0);
        job(8'd38, 32'd3831006429, 1'b0, 0);
        job(8'd39, 32'd2751352088, 1'b1, 0);
        job(8'd5, 32'd7, 1'b0, 7);

        accept(8'd20);
        chk("abort_busy_run", busy, 1);
        for (int i = 0; i < 4; i++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_req_ready", req_ready, 1);
        chk("abort_busy", busy, 0);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            if (res_valid) seen++;
            tick();
        end
        chk("abort_no_result", seen, 0);
        job(8'd4, 32'd4, 1'b0, 0);

        accept(8'd30);
        for (int i = 0; i < 5; i++) tick();
        chk("pre_reset_busy", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_req_ready", req_ready, 1);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_res_valid", res_valid, 0);
        chk("async_rst_res_data", res_data, 0);
        chk("async_rst_res_ovf", res_ovf, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        job(8'd7, 32'd24, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
